cic_interpolator: RTL and testbench

Three-stage CIC interpolator: the transmit-side counterpart of the array's CIC decimator. It accepts 16-bit samples at the low (16 kHz) rate through a valid/ready handshake and produces 24-bit samples at the high (3.072 MHz) rate, one per `tick`. It sits between the beamformer output path and the high-rate DAC/PDM modulator, and is also used as a high-rate stimulus source for the decimator.

---
 rtl/cic_interpolator_if.sv | 16 +
 rtl/cic_interpolator.sv | 92 +++++++++
 tb/tb_cic_interpolator.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cic_interpolator_if.sv
// cic_interpolator_if: low-rate sample handshake, high-rate tick and output bundle
interface cic_interpolator_if #(
   parameter int INPUT_WIDTH  = 16,
   parameter int OUTPUT_WIDTH = 24
);
   logic                           tick;
   logic signed [INPUT_WIDTH-1:0]  x_in;
   logic                           x_valid;
   logic                           x_ready;
   logic signed [OUTPUT_WIDTH-1:0] y_out;
   logic                           y_valid;
   logic                           underrun;
   logic                           sat;
   modport master (output tick, x_in, x_valid, input x_ready, y_out, y_valid, underrun, sat);
   modport slave (input tick, x_in, x_valid, output x_ready, y_out, y_valid, underrun, sat);
endinterface

// File: rtl/cic_interpolator.sv
// cic_interpolator: M-stage CIC interpolator, one held low-rate sample per R ticks, one output per tick
module cic_interpolator #(
   parameter int INPUT_WIDTH  = 16,
   parameter int OUTPUT_WIDTH = 24,
   parameter int M_STAGES     = 3,
   parameter int R_INTERP     = 192
) (
   input logic               clk,
   input logic               rst,
   cic_interpolator_if.slave bus
);
   localparam int LR = $clog2(R_INTERP);
   localparam int W = INPUT_WIDTH + M_STAGES * LR;
   localparam int SHIFT = INPUT_WIDTH + (M_STAGES - 1) * LR - OUTPUT_WIDTH;
   localparam logic [LR-1:0] LAST = LR'(R_INTERP - 1);
   localparam logic signed [OUTPUT_WIDTH-1:0] Y_MAX = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
   localparam logic signed [OUTPUT_WIDTH-1:0] Y_MIN = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};

   logic [LR-1:0]                  phase_q, phase_d;
   logic                           full_q, full_d;
   logic signed [INPUT_WIDTH-1:0]  hold_q, hold_d;
   logic signed [W-1:0]            d_q [M_STAGES];
   logic signed [W-1:0]            d_d [M_STAGES];
   logic signed [W-1:0]            i_q [M_STAGES];
   logic signed [W-1:0]            i_d [M_STAGES];
   logic signed [W-1:0]            c [M_STAGES+1];
   logic signed [W-1:0]            u, s;
   logic signed [OUTPUT_WIDTH-1:0] y_q, y_d;
   logic                           y_valid_q, under_q, under_d, sat_q, sat_d;
   logic                           due, consume, x_ready, xfer, hi, lo;

   assign bus.x_ready  = x_ready;
   assign bus.y_out    = y_q;
   assign bus.y_valid  = y_valid_q;
   assign bus.underrun = under_q;
   assign bus.sat      = sat_q;

   // Next state: hold register handshake, low-rate combs, zero-stuffed integrators, saturating output
   always_comb begin
      due = bus.tick && phase_q == '0;
      consume = due && full_q;
      x_ready = !full_q || consume;
      xfer = bus.x_valid && x_ready;
      full_d = xfer || (full_q && !consume);
      hold_d = xfer ? bus.x_in : hold_q;
      phase_d = !bus.tick ? phase_q : phase_q == LAST ? '0 : phase_q + LR'(1);
      under_d = under_q || (due && !full_q);
      c[0] = consume ? {{(W-INPUT_WIDTH){hold_q[INPUT_WIDTH-1]}}, hold_q} : '0;
      for (int k = 0; k < M_STAGES; k++) begin
         c[k+1] = c[k] - d_q[k];
         d_d[k] = due ? c[k] : d_q[k];
      end
      u = due ? c[M_STAGES] : '0;
      i_d[0] = bus.tick ? i_q[0] + u : i_q[0];
      for (int k = 1; k < M_STAGES; k++)
         i_d[k] = bus.tick ? i_q[k] + i_q[k-1] : i_q[k];
      s = i_q[M_STAGES-1] >>> SHIFT;
      hi = !s[W-1] && |s[W-2:OUTPUT_WIDTH-1];
      lo = s[W-1] && !(&s[W-2:OUTPUT_WIDTH-1]);
      y_d = !bus.tick ? y_q : hi ? Y_MAX : lo ? Y_MIN : s[OUTPUT_WIDTH-1:0];
      sat_d = sat_q || (bus.tick && (hi || lo));
   end

   // State registers, all cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q   <= '0;
         full_q    <= 1'b0;
         hold_q    <= '0;
         y_q       <= '0;
         y_valid_q <= 1'b0;
         under_q   <= 1'b0;
         sat_q     <= 1'b0;
         for (int k = 0; k < M_STAGES; k++) begin
            d_q[k] <= '0;
            i_q[k] <= '0;
         end
      end else begin
         phase_q   <= phase_d;
         full_q    <= full_d;
         hold_q    <= hold_d;
         y_q       <= y_d;
         y_valid_q <= bus.tick;
         under_q   <= under_d;
         sat_q     <= sat_d;
         for (int k = 0; k < M_STAGES; k++) begin
            d_q[k] <= d_d[k];
            i_q[k] <= i_d[k];
         end
      end
   end
endmodule

// File: tb/tb_cic_interpolator.sv
// tb_cic_interpolator: directed checks of reset, DC, full scale, impulse, throttled tick and underrun
module tb_cic_interpolator;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic xfer;
   int   n_cmp = 0;
   int   n_bad = 0;

   cic_interpolator_if bus ();
   cic_interpolator dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic t, input logic v, input logic signed [15:0] x);
      bus.tick = t;
      bus.x_valid = v;
      bus.x_in = x;
      #1 xfer = bus.x_valid && bus.x_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, '0);
      rst = 1'b0;
   endtask

   task automatic run_dc(input string pfx, input logic signed [15:0] val, input int per, input longint exp);
      int     ticks, pulses, stray, xfers, cycn;
      longint bad;
      logic   t;
      ticks = 0; pulses = 0; stray = 0; xfers = 0; cycn = 0; bad = exp;
      do_reset();
      cyc(1'b0, 1'b1, val);
      while (ticks < 5760) begin
         t = (cycn % per) == 0;
         cyc(t, 1'b1, val);
         cycn++;
         if (xfer) xfers++;
         if (bus.y_valid) pulses++;
         if (bus.y_valid != t) stray++;
         if (t) begin
            if (ticks >= 579 && bus.y_out != exp && bad == exp) bad = bus.y_out;
            ticks++;
         end
      end
      check({pfx, "_y_settled"}, bad, exp);
      check({pfx, "_pulses"}, pulses, 5760);
      check({pfx, "_stray_valid"}, stray, 0);
      check({pfx, "_transfers"}, xfers, 30);
      check({pfx, "_underrun"}, bus.underrun, 0);
      check({pfx, "_sat"}, bus.sat, 0);
   endtask

   initial begin
      longint sum, first_val, tail;
      int     first_idx;
      bus.tick = 1'b1;
      bus.x_valid = 1'b0;
      bus.x_in = '0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 1'b0, '0);
         check("rst_y", bus.y_out, 0);
         check("rst_yv", bus.y_valid, 0);
         check("rst_ready", bus.x_ready, 1);
         check("rst_underrun", bus.underrun, 0);
      end
      rst = 1'b0;
      cyc(1'b1, 1'b0, '0);
      check("rel_underrun", bus.underrun, 1);
      check("rel_y", bus.y_out, 0);

      run_dc("dc1000", 16'sd1000, 1, 144000);
      run_dc("fs_pos", 16'sd32767, 1, 4718448);
      run_dc("fs_neg", -16'sd32768, 1, -4718592);
      run_dc("thr1000", 16'sd1000, 4, 144000);

      do_reset();
      cyc(1'b0, 1'b1, 16'sd256);
      sum = 0; tail = 0; first_idx = -1; first_val = 0;
      for (int k = 0; k < 620; k++) begin
         cyc(1'b1, 1'b1, '0);
         if (first_idx < 0 && bus.y_out != 0) begin
            first_idx = k;
            first_val = bus.y_out;
         end
         if (k < 600) sum += bus.y_out;
         else tail += (bus.y_out < 0) ? -bus.y_out : bus.y_out;
      end
      check("imp_first_tick", first_idx, 3);
      check("imp_first_val", first_val, 1);
      check("imp_sum", sum, 7077888);
      check("imp_tail", tail, 0);

      do_reset();
      cyc(1'b0, 1'b1, 16'sd1000);
      for (int k = 0; k <= 450; k++) begin
         cyc(1'b1, !(k >= 100 && k <= 384), 16'sd1000);
         if (k == 383) check("ur_before", bus.underrun, 0);
         if (k == 384) check("ur_set", bus.underrun, 1);
      end
      check("ur_sticky", bus.underrun, 1);
      check("ur_y_live", bus.y_out != 0, 1);
      rst = 1'b1;
      cyc(1'b1, 1'b1, 16'sd1000);
      rst = 1'b0;
      check("mid_rst_y", bus.y_out, 0);
      check("mid_rst_yv", bus.y_valid, 0);
      check("mid_rst_underrun", bus.underrun, 0);
      check("mid_rst_sat", bus.sat, 0);
      check("mid_rst_ready", bus.x_ready, 1);
      cyc(1'b1, 1'b0, '0);
      check("mid_rst_phase0", bus.underrun, 1);
      check("mid_rst_y_after", bus.y_out, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
